// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and shared 12-bit colours.
// Used by the frame-buffer renderer and the display-side reader.
package vga_timing_pkg;
  localparam int VGA_PIX_DIV = 4;
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_WIN_W   = 512;
  localparam logic VGA_SYNC_POL = 1'b0;

  localparam int VGA_H_TOTAL =
    VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int CW = 10;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BLACK   = 12'h000;
  localparam rgb_t GREEN   = 12'h0F0;
  localparam rgb_t RED     = 12'hF00;
  localparam rgb_t CYAN    = 12'h0FF;
  localparam rgb_t MAGENTA = 12'hF0F;
  localparam rgb_t YELLOW  = 12'hFF0;
endpackage

// File: rtl/vga_sync_counter.sv
// Pixel divider plus h/v raster counters.
// Emits the pixel tick and raw fetch/sync flags for the current (h, v).
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = VGA_PIX_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP,
  parameter int WIN_W   = VGA_WIN_W
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          fetch,
  output logic          hs,
  output logic          vs,
  output logic          wrap
);
  localparam int HT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_VIS + H_FP;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_VIS + V_FP;
  localparam int VSE = VSS + V_SYNC;
  localparam int DW  = $clog2(PIX_DIV);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;

  assign tick   = (div == DW'(PIX_DIV - 1));
  assign h_last = (h == CW'(HT - 1));
  assign v_last = (v == CW'(VT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + CW'(1);
        end else begin
          h <= h + CW'(1);
        end
      end
    end
  end

  assign fetch = (h < CW'(WIN_W)) && (v < CW'(V_VIS));
  assign hs    = (h >= CW'(HSS)) && (h < CW'(HSE));
  assign vs    = (v >= CW'(VSS)) && (v < CW'(VSE));
  assign wrap  = tick && h_last && v_last;
endmodule

// File: rtl/vga_mem_reader.sv
// Display-side frame-buffer reader: fetch, capture and output pipeline.
// Address leads the displayed pixel by one pixel; syncs ride along.
module vga_mem_reader
  import vga_timing_pkg::*;
#(
  parameter int   PIX_DIV  = VGA_PIX_DIV,
  parameter int   H_VIS    = VGA_H_VIS,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_VIS    = VGA_V_VIS,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   WIN_W    = VGA_WIN_W,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  output logic [8:0]  mem_x,
  output logic [8:0]  mem_y,
  output logic        mem_rd,
  input  logic [11:0] mem_rgb,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  logic          tick;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          fetch;
  logic          hs;
  logic          vs;
  logic          wrap;

  vga_sync_counter #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .WIN_W   (WIN_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .h     (h),
    .v     (v),
    .fetch (fetch),
    .hs    (hs),
    .vs    (vs),
    .wrap  (wrap)
  );

  logic fetch_q;
  logic hs_q;
  logic vs_q;
  logic rd_q;
  logic fresh;
  rgb_t hold;
  rgb_t pix;

  // With PIX_DIV == 2 the capture clk is also the output tick
  assign pix = rd_q ? mem_rgb : hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_x       <= '0;
      mem_y       <= '0;
      mem_rd      <= 1'b0;
      rd_q        <= 1'b0;
      hold        <= BLACK;
      fetch_q     <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      rgb         <= BLACK;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      fresh       <= 1'b1;
    end else begin
      fresh       <= 1'b0;
      frame_start <= fresh | wrap;
      mem_rd      <= tick & fetch;
      rd_q        <= mem_rd;
      if (rd_q) hold <= mem_rgb;
      if (tick) begin
        if (fetch) begin
          mem_x <= h[8:0];
          mem_y <= v[8:0];
        end
        fetch_q <= fetch;
        hs_q    <= hs;
        vs_q    <= vs;
        rgb     <= fetch_q ? pix : BLACK;
        hsync   <= hs_q ? SYNC_POL : ~SYNC_POL;
        vsync   <= vs_q ? SYNC_POL : ~SYNC_POL;
      end
    end
  end
endmodule

// File: tb/tb_vga_mem_reader.sv
// Directed bench for vga_mem_reader on a shrunken raster
// (24x12 pixels, 16x8 visible, 12-wide window, PIX_DIV = 2).
module tb_vga_mem_reader;
  localparam int PD = 2;
  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
  localparam int WW = 12;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  mem_x;
  logic [8:0]  mem_y;
  logic        mem_rd;
  logic [11:0] mem_rgb = 12'h000;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  bit mode_fff = 1'b0;

  vga_mem_reader #(
    .PIX_DIV  (PD),
    .H_VIS    (HV),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_VIS    (VV),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .WIN_W    (WW),
    .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_x       (mem_x),
    .mem_y       (mem_y),
    .mem_rd      (mem_rd),
    .mem_rgb     (mem_rgb),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Buffer model: data valid only in the clk after mem_rd
  always @(posedge clk) begin
    if (mem_rd)
      mem_rgb <= mode_fff ? 12'hFFF
                          : {mem_x[3:0], mem_y[3:0], 4'hA};
    else
      mem_rgb <= 12'h5A5;
  end

  task automatic wait_fs(input string tag);
    int n = 0;
    while (!frame_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) begin
      errors++;
      $display("FAIL %s: frame_start timeout, got 0 want 1", tag);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL rst_rgb: got %h want 000", rgb);
    end
    if (hsync !== 1'b1) begin
      errors++; $display("FAIL rst_hsync: got %b want 1", hsync);
    end
    if (vsync !== 1'b1) begin
      errors++; $display("FAIL rst_vsync: got %b want 1", vsync);
    end
    if (mem_rd !== 1'b0) begin
      errors++; $display("FAIL rst_rd: got %b want 0", mem_rd);
    end
    if (mem_x !== 9'd0) begin
      errors++; $display("FAIL rst_x: got %0d want 0", mem_x);
    end
    if (mem_y !== 9'd0) begin
      errors++; $display("FAIL rst_y: got %0d want 0", mem_y);
    end
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL rst_fs: got %b want 0", frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL fs_first: got %b want 1", frame_start);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL fs_width: got %b want 0", frame_start);
    end
  endtask

  // Fall-to-fall period and low width of an active-low sync
  task automatic measure(input bit sel, output int w, output int p);
    bit prev;
    bit cur;
    int n = 0;
    w = -1;
    p = -1;
    prev = sel ? vsync : hsync;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      cur = sel ? vsync : hsync;
      if (prev && !cur) break;
      prev = cur;
    end
    n = 0;
    prev = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      cur = sel ? vsync : hsync;
      if (!prev && cur) w = n;
      if (prev && !cur) begin
        p = n;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic test_syncs;
    int w;
    int p;
    measure(1'b0, w, p);
    checks += 2;
    if (w != HS * PD) begin
      errors++; $display("FAIL hs_width: got %0d want %0d", w, HS * PD);
    end
    if (p != HT * PD) begin
      errors++; $display("FAIL hs_period: got %0d want %0d", p, HT * PD);
    end
    measure(1'b1, w, p);
    checks += 2;
    if (w != VS * HT * PD) begin
      errors++; $display("FAIL vs_width: got %0d want %0d", w, VS * HT * PD);
    end
    if (p != VT * HT * PD) begin
      errors++;
      $display("FAIL vs_period: got %0d want %0d", p, VT * HT * PD);
    end
  endtask

  task automatic test_pixel;
    int n = 0;
    mode_fff = 1'b0;
    while (!(mem_rd && mem_x == 9'd5 && mem_y == 9'd7) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_rd && mem_x == 9'd5 && mem_y == 9'd7)) begin
      errors++; $display("FAIL pix_fetch: (5,7) got 0 want 1");
      return;
    end
    checks++;
    if (rgb !== 12'h47A) begin
      errors++; $display("FAIL pix_4_7: got %h want 47A", rgb);
    end
    repeat (PD) @(negedge clk);
    checks += 2;
    if (rgb !== 12'h57A) begin
      errors++; $display("FAIL pix_5_7: got %h want 57A", rgb);
    end
    if (mem_x !== 9'd6) begin
      errors++; $display("FAIL pix_lead: got %0d want 6", mem_x);
    end
    repeat (6 * PD) @(negedge clk);
    checks++;
    if (rgb !== 12'hB7A) begin
      errors++; $display("FAIL pix_win_edge: got %h want B7A", rgb);
    end
    repeat (PD) @(negedge clk);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL pix_past_win: got %h want 000", rgb);
    end
  endtask

  task automatic test_window;
    int n = 0;
    int rd_cnt = 0, rd_wide = 0, rd_out = 0;
    int nz = 0, fff = 0, nz_sync = 0, run = 0, run_max = 0;
    bit prev_rd = 1'b0;
    mode_fff = 1'b1;
    @(negedge clk);
    wait_fs("win_start");
    do begin
      @(negedge clk);
      n++;
      if (mem_rd) rd_cnt++;
      if (mem_rd && prev_rd) rd_wide++;
      if (mem_rd && (mem_x >= 9'(WW) || mem_y >= 9'(VV))) rd_out++;
      if (rgb != 12'h000) begin
        nz++;
        run++;
        if (run > run_max) run_max = run;
        if (!hsync || !vsync) nz_sync++;
      end else begin
        run = 0;
      end
      if (rgb == 12'hFFF) fff++;
      prev_rd = mem_rd;
    end while (!frame_start && n < 2000);
    checks += 9;
    if (n != VT * HT * PD) begin
      errors++; $display("FAIL fs_period: got %0d want %0d", n, VT * HT * PD);
    end
    if (rd_cnt != WW * VV) begin
      errors++; $display("FAIL rd_count: got %0d want %0d", rd_cnt, WW * VV);
    end
    if (rd_wide != 0) begin
      errors++; $display("FAIL rd_width: got %0d wide want 0", rd_wide);
    end
    if (rd_out != 0) begin
      errors++; $display("FAIL rd_outside: got %0d want 0", rd_out);
    end
    if (nz != WW * VV * PD) begin
      errors++; $display("FAIL rgb_nz: got %0d want %0d", nz, WW * VV * PD);
    end
    if (fff != WW * VV * PD) begin
      errors++; $display("FAIL rgb_fff: got %0d want %0d", fff, WW * VV * PD);
    end
    if (nz_sync != 0) begin
      errors++; $display("FAIL rgb_in_sync: got %0d want 0", nz_sync);
    end
    if (run_max != WW * PD) begin
      errors++; $display("FAIL rgb_run: got %0d want %0d", run_max, WW * PD);
    end
    if (mem_x !== 9'(WW - 1) || mem_y !== 9'(VV - 1)) begin
      errors++;
      $display("FAIL addr_hold: got (%0d,%0d) want (%0d,%0d)",
               mem_x, mem_y, WW - 1, VV - 1);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    mode_fff = 1'b0;
    @(negedge clk);
    wait_fs("mid_start");
    repeat ((5 * HT + 10) * PD) @(negedge clk);
    checks++;
    if (rgb == 12'h000) begin
      errors++; $display("FAIL mid_pre_rgb: got 000 want nonzero");
    end
    rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL mid_rgb: got %h want 000", rgb);
    end
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      errors++; $display("FAIL mid_sync: got %b%b want 11", hsync, vsync);
    end
    if (mem_rd !== 1'b0) begin
      errors++; $display("FAIL mid_rd: got %b want 0", mem_rd);
    end
    if (mem_x !== 9'd0 || mem_y !== 9'd0) begin
      errors++; $display("FAIL mid_addr: got (%0d,%0d) want (0,0)", mem_x, mem_y);
    end
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL mid_fs0: got %b want 0", frame_start);
    end
    if (mem_rgb === 12'h000) begin
      errors++; $display("FAIL mid_mem: got 000 want nonzero model data");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL mid_fs1: got %b want 1", frame_start);
    end
    n = 1;
    while (hsync && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != (HV + HF + 2) * PD) begin
      errors++;
      $display("FAIL mid_hs_restart: got %0d want %0d", n, (HV + HF + 2) * PD);
    end
  endtask

  initial begin
    test_reset();
    test_syncs();
    test_pixel();
    test_window();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
